// File: rtl/spmv_row_accumulator.sv
// Sparse matrix-vector row accumulator: collects signed partial sums per row id,
// then streams out every row in ascending order on a flush, clearing each as it leaves.
module spmv_row_accumulator #(
   parameter int IN_WIDTH  = 37,
   parameter int ID_WIDTH  = 5,
   parameter int ACC_WIDTH = 48
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [ID_WIDTH-1:0]  in_id,
   input  logic [IN_WIDTH-1:0]  in_val,
   output logic                 in_ready,
   input  logic                 flush_valid,
   output logic                 flush_ready,
   output logic                 out_valid,
   output logic [ID_WIDTH-1:0]  out_id,
   output logic [ACC_WIDTH-1:0] out_val,
   output logic                 out_last,
   input  logic                 out_ready,
   output logic                 busy
);
   localparam int NUM_ROWS = 2**ID_WIDTH;

   typedef enum logic {ST_ACCUM = 1'b0, ST_DRAIN = 1'b1} state_t;

   state_t                 r_state;
   logic [ID_WIDTH-1:0]    r_idx;
   logic [ACC_WIDTH-1:0]   r_acc [NUM_ROWS];

   logic [ACC_WIDTH-1:0]   w_in_ext;
   logic                   w_accum;
   logic                   w_in_fire;
   logic                   w_out_fire;
   logic                   w_last;

   // Replicating the sign bit ACC-IN+1 times keeps this legal when the widths are equal.
   assign w_in_ext   = {{(ACC_WIDTH-IN_WIDTH+1){in_val[IN_WIDTH-1]}}, in_val[IN_WIDTH-2:0]};
   assign w_accum    = (r_state == ST_ACCUM);
   assign w_in_fire  = w_accum && in_valid;
   assign w_out_fire = !w_accum && out_ready;
   assign w_last     = &r_idx;

   assign in_ready    = w_accum;
   assign flush_ready = w_accum;
   assign out_valid   = !w_accum;
   assign busy        = !w_accum;
   assign out_id      = r_idx;
   assign out_val     = r_acc[r_idx];
   assign out_last    = !w_accum && w_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_ACCUM;
         r_idx   <= '0;
         for (int i = 0; i < NUM_ROWS; i++) begin
            r_acc[i] <= '0;
         end
      end else begin
         case (r_state)
            ST_ACCUM: begin
               if (w_in_fire) begin
                  r_acc[in_id] <= r_acc[in_id] + w_in_ext;
               end
               if (flush_valid) begin
                  r_state <= ST_DRAIN;
                  r_idx   <= '0;
               end
            end
            ST_DRAIN: begin
               // Clearing on the way out leaves every row zero once the drain ends.
               if (w_out_fire) begin
                  r_acc[r_idx] <= '0;
                  r_idx        <= r_idx + 1'b1;
                  if (w_last) begin
                     r_state <= ST_ACCUM;
                  end
               end
            end
            default: r_state <= ST_ACCUM;
         endcase
      end
   end
endmodule

// File: tb/tb_spmv_row_accumulator.sv
// Directed and randomized checks of spmv_row_accumulator against a per-row sum model.
module tb_spmv_row_accumulator;
   localparam int IW  = 37;
   localparam int IDW = 5;
   localparam int AW  = 48;
   localparam int NUM = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid, flush_valid, out_ready;
   logic [IDW-1:0] in_id;
   logic [IW-1:0]  in_val;
   logic           in_ready, flush_ready, out_valid, out_last, busy;
   logic [IDW-1:0] out_id;
   logic [AW-1:0]  out_val;

   logic           w8_in_valid, w8_flush_valid, w8_out_ready;
   logic [1:0]     w8_in_id;
   logic [7:0]     w8_in_val;
   logic           w8_in_ready, w8_flush_ready, w8_out_valid, w8_out_last, w8_busy;
   logic [1:0]     w8_out_id;
   logic [7:0]     w8_out_val;

   int             tests  = 0;
   int             failed = 0;
   logic [AW-1:0]  model [NUM];

   always #5 clk = ~clk;

   spmv_row_accumulator #(.IN_WIDTH(IW), .ID_WIDTH(IDW), .ACC_WIDTH(AW)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_id(in_id), .in_val(in_val), .in_ready(in_ready),
      .flush_valid(flush_valid), .flush_ready(flush_ready),
      .out_valid(out_valid), .out_id(out_id), .out_val(out_val), .out_last(out_last),
      .out_ready(out_ready), .busy(busy)
   );

   spmv_row_accumulator #(.IN_WIDTH(8), .ID_WIDTH(2), .ACC_WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst),
      .in_valid(w8_in_valid), .in_id(w8_in_id), .in_val(w8_in_val), .in_ready(w8_in_ready),
      .flush_valid(w8_flush_valid), .flush_ready(w8_flush_ready),
      .out_valid(w8_out_valid), .out_id(w8_out_id), .out_val(w8_out_val), .out_last(w8_out_last),
      .out_ready(w8_out_ready), .busy(w8_busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < NUM; i++) model[i] = '0;
   endtask

   function automatic logic [IW-1:0] rand_val();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[IW-1:0];
   endfunction

   // Offer one partial sum (optionally with a flush in the same cycle) and fold it into the model.
   task automatic send(input int id, input logic [IW-1:0] v, input bit with_flush);
      logic signed [63:0] sv;
      chk("in_ready_accum", in_ready, 1);
      in_valid    = 1'b1;
      in_id       = IDW'(id);
      in_val      = v;
      flush_valid = with_flush;
      tick();
      in_valid    = 1'b0;
      flush_valid = 1'b0;
      sv          = 64'($signed(v));
      model[id]   = AW'(64'(model[id]) + sv);
      $display("[TB] input id=%0d val=%0d flush=%0d", id, $signed(v), with_flush);
   endtask

   task automatic flush_cmd();
      chk("flush_ready_accum", flush_ready, 1);
      flush_valid = 1'b1;
      tick();
      flush_valid = 1'b0;
   endtask

   // Consume one full drain; noise on in_valid/flush_valid must be ignored while draining.
   task automatic drain(input int ready_pct, output int cycles);
      int r;
      r      = 0;
      cycles = 0;
      while (r < NUM && cycles < 2000) begin
         chk("out_valid", out_valid, 1);
         chk("busy", busy, 1);
         chk("in_ready_drain", in_ready, 0);
         chk("flush_ready_drain", flush_ready, 0);
         chk("out_id", out_id, r);
         chk("out_val", out_val, model[r]);
         chk("out_last", out_last, (r == NUM-1));
         out_ready   = ($urandom_range(99) < ready_pct);
         flush_valid = 1'($urandom_range(1));
         in_valid    = 1'($urandom_range(1));
         in_id       = IDW'($urandom_range(NUM-1));
         in_val      = rand_val();
         if (out_ready) $display("[TB] output id=%0d val=%0h last=%0d", out_id, out_val, out_last);
         tick();
         cycles++;
         if (out_ready) r++;
      end
      out_ready   = 1'b0;
      flush_valid = 1'b0;
      in_valid    = 1'b0;
      chk("drain_rows", r, NUM);
      chk("in_ready_after", in_ready, 1);
      chk("out_valid_after", out_valid, 0);
      chk("busy_after", busy, 0);
      model_clear();
   endtask

   initial begin
      int cyc;
      rst = 1'b1;
      in_valid = 0; in_id = '0; in_val = '0; flush_valid = 0; out_ready = 0;
      w8_in_valid = 0; w8_in_id = '0; w8_in_val = '0; w8_flush_valid = 0; w8_out_ready = 0;
      model_clear();
      repeat (3) tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_flush_ready", flush_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      tick();
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_busy", busy, 0);

      // Basic accumulate with full-rate drain
      send(3, IW'(10), 0);
      send(3, -IW'(4), 0);
      send(7, IW'(5), 0);
      chk("basic_model_id3", model[3], AW'(6));
      flush_cmd();
      drain(100, cyc);
      chk("busy_cycles", cyc, NUM);

      // Back-to-back same id
      for (int k = 0; k < 8; k++) send(0, IW'(1), 0);
      flush_cmd();
      drain(100, cyc);

      // Input and flush in the same cycle, then an empty drain
      send(2, IW'(9), 1);
      drain(100, cyc);
      flush_cmd();
      drain(100, cyc);

      // Random accumulation with backpressure, several rounds
      for (int round = 0; round < 3; round++) begin
         for (int k = 0; k < 40; k++) send($urandom_range(NUM-1), rand_val(), 0);
         flush_cmd();
         drain(50, cyc);
      end

      // Reset mid-drain
      send(9, IW'(77), 0);
      send(20, rand_val(), 0);
      flush_cmd();
      out_ready = 1'b1;
      repeat (5) tick();
      chk("mid_drain_id", out_id, 5);
      rst = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_out_last", out_last, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      rst = 1'b0;
      model_clear();
      tick();
      send(4, IW'(3), 0);
      flush_cmd();
      drain(100, cyc);

      // Wrap on the 8-bit instance: 127 + 1 -> -128
      w8_in_valid = 1'b1; w8_in_id = 2'd1; w8_in_val = 8'd127;
      tick();
      w8_in_val = 8'd1;
      tick();
      w8_in_valid = 1'b0;
      w8_flush_valid = 1'b1;
      tick();
      w8_flush_valid = 1'b0;
      w8_out_ready = 1'b1;
      for (int r = 0; r < 4; r++) begin
         chk("w8_out_valid", w8_out_valid, 1);
         chk("w8_out_id", w8_out_id, r);
         chk("w8_out_val", w8_out_val, (r == 1) ? 8'h80 : 8'h00);
         chk("w8_out_last", w8_out_last, (r == 3));
         $display("[TB] w8 output id=%0d val=%0d", w8_out_id, $signed(w8_out_val));
         tick();
      end
      w8_out_ready = 1'b0;
      chk("w8_done", w8_out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
